// File: rtl/log_dump_controller.sv
`default_nettype none
// ============================================================================
//  Module   : log_dump_controller
//  Purpose  : Runs one capture-and-dump cycle of the equalizer data logger.
//             A host start command latches the log source and arms capture.
//             The block then waits for capture completion and reads the
//             logger RAM back word by word. Each 32-bit word is sent MSB-first
//             as a byte stream using a valid/ready handshake.
//  Options  : DUMP_HEADER_EN - when defined, a 3-byte header is sent before
//             the data: A5, 5A, {5'b0, sel}.
//  Ports    : clk, i_reset (sync, active-high)
//             i_cmd_start/i_cmd_sel/i_cmd_abort  - host command interface
//             i_capture_done, i_ram_data          - logger status / read data
//             o_data_sel, o_en_write, o_en_read,
//             o_read_adrs                         - logger control
//             o_byte, o_byte_valid, i_byte_ready  - byte stream to UART
//             o_busy, o_done, o_err               - status
//  Revision : 1.0 - initial release
// ============================================================================
module log_dump_controller #(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = 32768,
    parameter int N_WORDS      = 32768,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_start,
    input  logic [2:0]           i_cmd_sel,
    input  logic                 i_cmd_abort,
    input  logic                 i_capture_done,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    input  logic                 i_byte_ready,
    output logic [2:0]           o_data_sel,
    output logic                 o_en_write,
    output logic                 o_en_read,
    output logic [AW-1:0]        o_read_adrs,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int AW1 = AW + 1;
    localparam int LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [AW:0]   c_last_addr = AW1'(N_WORDS - 1);
    localparam logic [LW-1:0] c_lat_last  = LW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
`ifdef DUMP_HEADER_EN
        S_HEADER  = 3'd3,
`endif
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_SEND    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t         r_state, w_state_next;
    logic [2:0]     r_sel, w_sel_next;
    // One bit wider than the RAM address so N_WORDS == RAM_DEPTH cannot wrap.
    logic [AW:0]    r_addr, w_addr_next;
    logic [LW-1:0]  r_lat, w_lat_next;
    logic [31:0]    r_shift, w_shift_next;
    logic [1:0]     r_cnt, w_cnt_next;
    logic [7:0]     r_byte, w_byte_next;
    logic           r_valid, w_valid_next;
    logic [AW-1:0]  r_adrs, w_adrs_next;
    logic           r_err, w_err_next;
    logic           r_en_write, r_en_read, r_busy, r_done;
    logic           w_en_read_next;
    logic           w_xfer;

    // Byte idx of the captured word, MSB first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

    assign w_xfer = r_valid & i_byte_ready;

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_addr_next  = r_addr;
        w_lat_next   = r_lat;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_byte_next  = r_byte;
        w_valid_next = r_valid;
        w_adrs_next  = r_adrs;
        w_err_next   = 1'b0;

        if (i_cmd_abort) begin
            // Abort wins over everything, including a same-cycle start.
            w_state_next = S_IDLE;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_start) begin
                        if (i_cmd_sel == 3'b001 || i_cmd_sel == 3'b010 || i_cmd_sel == 3'b011) begin
                            w_sel_next   = i_cmd_sel;
                            w_addr_next  = '0;
                            w_state_next = S_ARM;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                end
                // A capture_done arriving while in ARM is deliberately ignored.
                S_ARM: w_state_next = S_CAPTURE;
                S_CAPTURE: begin
                    if (i_capture_done) begin
                        w_cnt_next   = 2'd0;
                        w_valid_next = 1'b0;
`ifdef DUMP_HEADER_EN
                        w_state_next = S_HEADER;
`else
                        w_state_next = S_RD_REQ;
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                S_HEADER: begin
                    if (!r_valid) begin
                        w_byte_next  = 8'hA5;
                        w_valid_next = 1'b1;
                    end else if (w_xfer) begin
                        if (r_cnt == 2'd2) begin
                            w_valid_next = 1'b0;
                            w_cnt_next   = 2'd0;
                            w_state_next = S_RD_REQ;
                        end else begin
                            w_cnt_next  = r_cnt + 2'd1;
                            w_byte_next = (r_cnt == 2'd0) ? 8'h5A : {5'b0, r_sel};
                        end
                    end
                end
`endif
                S_RD_REQ: begin
                    w_lat_next   = '0;
                    w_state_next = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_lat == c_lat_last) begin
                        w_shift_next = i_ram_data;
                        w_cnt_next   = 2'd0;
                        w_valid_next = 1'b0;
                        w_state_next = S_SEND;
                    end else begin
                        w_lat_next = r_lat + 1'b1;
                    end
                end
                S_SEND: begin
                    // First SEND cycle presents the MSB; each transfer advances.
                    if (!r_valid) begin
                        w_byte_next  = word_byte(r_shift, 2'd0);
                        w_valid_next = 1'b1;
                    end else if (w_xfer) begin
                        if (r_cnt == 2'd3) begin
                            w_valid_next = 1'b0;
                            if (r_addr == c_last_addr) begin
                                w_state_next = S_DONE;
                            end else begin
                                w_addr_next  = r_addr + 1'b1;
                                w_state_next = S_RD_REQ;
                            end
                        end else begin
                            w_cnt_next  = r_cnt + 2'd1;
                            w_byte_next = word_byte(r_shift, r_cnt + 2'd1);
                        end
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end

        // The read address is registered on entry to RD_REQ so the RAM sees
        // it throughout RD_REQ and the latency count starts in RD_WAIT.
        if (w_state_next == S_RD_REQ) begin
            w_adrs_next = w_addr_next[AW-1:0];
        end

        w_en_read_next = (w_state_next == S_RD_REQ)  || (w_state_next == S_RD_WAIT) ||
                         (w_state_next == S_SEND)    || (w_state_next == S_DONE);
`ifdef DUMP_HEADER_EN
        if (w_state_next == S_HEADER) begin
            w_en_read_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_addr     <= '0;
            r_lat      <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_byte     <= '0;
            r_valid    <= 1'b0;
            r_adrs     <= '0;
            r_err      <= 1'b0;
            r_en_write <= 1'b0;
            r_en_read  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_addr     <= w_addr_next;
            r_lat      <= w_lat_next;
            r_shift    <= w_shift_next;
            r_cnt      <= w_cnt_next;
            r_byte     <= w_byte_next;
            r_valid    <= w_valid_next;
            r_adrs     <= w_adrs_next;
            r_err      <= w_err_next;
            // Status outputs are registered from the next state so they are
            // aligned with the state they describe.
            r_en_write <= (w_state_next == S_ARM);
            r_en_read  <= w_en_read_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    assign o_data_sel   = r_sel;
    assign o_en_write   = r_en_write;
    assign o_en_read    = r_en_read;
    assign o_read_adrs  = r_adrs;
    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_log_dump_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_log_dump_controller
//  Purpose  : Self-checking bench for log_dump_controller. Two instances run
//             side by side (read latency 1 and 2) against small RAM models.
//             Expected byte streams are built from the RAM contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_log_dump_controller;

    localparam int DEPTH = 16;
    localparam int NW    = 4;
`ifdef DUMP_HEADER_EN
    localparam int HDR = 3;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_start, cmd_abort, capture_done, byte_ready;
    logic [2:0]  cmd_sel;
    logic [31:0] mem [DEPTH];
    logic [31:0] ram1, ram2, ram2_p;

    logic [2:0] sel1, sel2;
    logic       wr1, wr2, rd1, rd2, v1, v2, busy1, busy2, done1, done2, err1, err2;
    logic [3:0] adrs1, adrs2;
    logic [7:0] byte1, byte2;

    log_dump_controller #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .N_WORDS(NW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .i_reset(rst), .i_cmd_start(cmd_start), .i_cmd_sel(cmd_sel),
        .i_cmd_abort(cmd_abort), .i_capture_done(capture_done), .i_ram_data(ram1),
        .i_byte_ready(byte_ready), .o_data_sel(sel1), .o_en_write(wr1), .o_en_read(rd1),
        .o_read_adrs(adrs1), .o_byte(byte1), .o_byte_valid(v1), .o_busy(busy1),
        .o_done(done1), .o_err(err1));

    log_dump_controller #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .N_WORDS(NW), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .i_reset(rst), .i_cmd_start(cmd_start), .i_cmd_sel(cmd_sel),
        .i_cmd_abort(cmd_abort), .i_capture_done(capture_done), .i_ram_data(ram2),
        .i_byte_ready(byte_ready), .o_data_sel(sel2), .o_en_write(wr2), .o_en_read(rd2),
        .o_read_adrs(adrs2), .o_byte(byte2), .o_byte_valid(v2), .o_busy(busy2),
        .o_done(done2), .o_err(err2));

    // RAM models: one and two cycles of read latency.
    always @(posedge clk) begin
        ram1   <= mem[adrs1];
        ram2_p <= mem[adrs2];
        ram2   <= ram2_p;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] got1[$], got2[$], expq[$];
    logic [3:0] adrs_seq[$];
    int n_done1, n_done2, n_wr, t_first1, t_first2, t_word1, stab_bad;
    logic glitch_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < DEPTH; i++) mem[i] = ramp ? (32'h11223344 + 32'(i)) : $urandom;
    endtask

    // Expected stream from the RAM image: optional header, then words MSB-first.
    task automatic build_exp(input logic [2:0] sel);
        expq.delete();
        if (HDR == 3) begin
            expq.push_back(8'hA5);
            expq.push_back(8'h5A);
            expq.push_back({5'b0, sel});
        end
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++)
                expq.push_back(8'((mem[w] >> (24 - 8 * b)) & 32'hFF));
    endtask

    task automatic check_stream(input string tag, input logic [7:0] q[$]);
        chk({tag, "_len"}, 32'(q.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(q[i]), 32'(expq[i]));
    endtask

    // rmode: 0 ready high, 1 ready toggling, 2 random ready.
    // abort_at > 0: abort on that valid-high cycle of dut1.
    task automatic run_dump(input logic [2:0] sel, input int rmode, input int abort_at, input bit glitch);
        int wr_cyc, vcount;
        bit d1, d2, aborted;
        logic pv, pr;
        logic [7:0] pb;
        got1.delete(); got2.delete(); adrs_seq.delete();
        n_done1 = 0; n_done2 = 0; n_wr = 0; stab_bad = 0;
        t_first1 = -1; t_first2 = -1; t_word1 = -1; glitch_rd = 1'b0;
        wr_cyc = -100; vcount = 0; d1 = 0; d2 = 0; aborted = 0;
        pv = 0; pr = 0; pb = 0;
        build_exp(sel);
        @(negedge clk);
        cmd_sel = sel; cmd_start = 1'b1; byte_ready = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            cmd_start = 1'b0; capture_done = 1'b0; cmd_abort = 1'b0;
            if (wr1) begin n_wr++; wr_cyc = cyc; end
            if (done1) begin n_done1++; d1 = 1; end
            if (done2) begin n_done2++; d2 = 1; end
            if (rd1 && (adrs_seq.size() == 0 || adrs_seq[$] != adrs1)) adrs_seq.push_back(adrs1);
            if (pv && !pr && v1 && byte1 != pb) stab_bad++;
            if (pv && !pr && !v1) stab_bad++;
            if (glitch && cyc == wr_cyc + 2) glitch_rd = rd1;
            case (rmode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = (cyc % 2 == 0);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            if (glitch && cyc == wr_cyc) capture_done = 1'b1;
            if (cyc == wr_cyc + 3) capture_done = 1'b1;
            if (v1) vcount++;
            if (abort_at > 0 && v1 && vcount == abort_at) begin
                cmd_abort = 1'b1;
                aborted = 1;
            end
            if (v1 && byte_ready && !aborted) begin
                if (got1.size() == HDR) t_first1 = cyc;
                if (got1.size() == HDR + 4) t_word1 = cyc;
                got1.push_back(byte1);
            end
            if (v2 && byte_ready && !aborted) begin
                if (got2.size() == HDR) t_first2 = cyc;
                got2.push_back(byte2);
            end
            pv = v1; pr = byte_ready; pb = byte1;
            if (aborted || (d1 && d2)) break;
        end
        if (aborted) begin
            @(negedge clk);
            cmd_abort = 1'b0;
            chk("abort_valid", 32'(v1), 0);
            chk("abort_busy", 32'(busy1), 0);
            chk("abort_en_read", 32'(rd1), 0);
        end else begin
            chk("dump_finished", 32'(d1 & d2), 1);
        end
    endtask

    initial begin
        int n_err, n_busy, n_wr_b;
        rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; capture_done = 1'b0;
        byte_ready = 1'b0; cmd_sel = 3'b000;
        fill_mem(1);
        repeat (3) @(negedge clk);
        chk("rst_data_sel", 32'(sel1), 0);
        chk("rst_read_adrs", 32'(adrs1), 0);
        chk("rst_byte", 32'(byte1), 0);
        chk("rst_ctrl", {26'b0, wr1, rd1, v1, busy1, done1, err1}, 0);
        rst = 1'b0;

        // Ramp data, sel 010, ready high, capture pulse also during ARM.
        run_dump(3'b010, 0, 0, 1);
        check_stream("rampL1", got1);
        check_stream("rampL2", got2);
        chk("ramp_done_count", 32'(n_done1), 1);
        chk("ramp_en_write_count", 32'(n_wr), 1);
        chk("arm_capture_ignored", 32'(glitch_rd), 0);
        chk("adrs_visits", 32'(adrs_seq.size()), NW);
        for (int i = 0; i < NW && i < adrs_seq.size(); i++)
            chk($sformatf("adrs_%0d", i), 32'(adrs_seq[i]), 32'(i));
        chk("latency2_extra_cycle", 32'(t_first2 - t_first1), 1);
        chk("word_period_L1", 32'(t_word1 - t_first1), 7);
        @(negedge clk);
        chk("post_dump_busy", 32'(busy1), 0);
        chk("post_dump_sel", 32'(sel1), 3'b010);

        // Illegal select.
        n_err = 0; n_busy = 0; n_wr_b = 0;
        cmd_sel = 3'b101; cmd_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            n_err  += int'(err1);
            n_busy += int'(busy1);
            n_wr_b += int'(wr1);
        end
        chk("illegal_err_pulses", 32'(n_err), 1);
        chk("illegal_busy", 32'(n_busy), 0);
        chk("illegal_en_write", 32'(n_wr_b), 0);
        chk("illegal_sel_kept", 32'(sel1), 3'b010);

        // Abort beats a same-cycle start.
        cmd_sel = 3'b001; cmd_start = 1'b1; cmd_abort = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        chk("abort_prio_busy", 32'(busy1), 0);
        chk("abort_prio_en_write", 32'(wr1), 0);

        // Ready toggling every cycle.
        fill_mem(0);
        run_dump(3'b001, 1, 0, 0);
        check_stream("toggle", got1);
        chk("toggle_stall_stable", 32'(stab_bad), 0);
        chk("toggle_done_count", 32'(n_done1), 1);

        // Abort on the 6th sending cycle, then a complete dump.
        fill_mem(0);
        run_dump(3'b011, 0, 6, 0);
        repeat (3) @(negedge clk);
        fill_mem(0);
        run_dump(3'b011, 2, 0, 0);
        check_stream("after_abort", got1);
        chk("after_abort_stall_stable", 32'(stab_bad), 0);
        chk("after_abort_done_count", 32'(n_done1), 1);
        chk("after_abort_sel", 32'(sel1), 3'b011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
